// File: rtl/udp_header_insert.sv
// Prepends an 8-byte UDP header beat to each 64-bit AXI-Stream payload and emits IP-level metadata.
// Optional payload length checking is enabled with `define UDP_LEN_CHECK_EN.
module udp_header_insert #(
  parameter int DATA_WIDTH   = 64,
  parameter int META_WIDTH   = 128,
  parameter int IPMETA_WIDTH = 80
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [META_WIDTH-1:0]   s_meta,
  input  logic                    s_meta_valid,
  output logic                    s_meta_ready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [7:0]              s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [7:0]              m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [IPMETA_WIDTH-1:0] m_ipmeta,
  output logic                    m_ipmeta_valid,
  input  logic                    m_ipmeta_ready,
  output logic                    len_err,
  output logic [15:0]             len_err_cnt
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t      state, state_nx;
  logic        adv;
  logic        meta_hs;
  logic        pay_hs;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [15:0] payload_len;
  logic [15:0] udp_len;
  logic [15:0] meta_udp_len;
  logic [63:0] hdr_word;

  assign adv          = !m_axis_tvalid || m_axis_tready;
  assign meta_hs      = s_meta_ready && s_meta_valid;
  assign pay_hs       = s_axis_tready && s_axis_tvalid;
  assign meta_udp_len = s_meta[31:16] + 16'd8;

  // Byte lane 0 goes first on the wire, so each 16-bit field is byte-swapped into network order.
  assign hdr_word = {16'h0000, udp_len[7:0], udp_len[15:8],
                     dst_port[7:0], dst_port[15:8], src_port[7:0], src_port[15:8]};

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    s_meta_ready  = 1'b0;
    s_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        s_meta_ready = rstn && !m_ipmeta_valid && adv;
        if (s_meta_ready && s_meta_valid) state_nx = HEADER;
      end
      HEADER: begin
        if (adv) state_nx = (payload_len == 16'd0) ? IDLE : PAYLOAD;
      end
      PAYLOAD: begin
        s_axis_tready = rstn && adv;
        if (s_axis_tready && s_axis_tvalid && s_axis_tlast) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      src_port       <= '0;
      dst_port       <= '0;
      payload_len    <= '0;
      udp_len        <= '0;
      m_ipmeta       <= '0;
      m_ipmeta_valid <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tkeep   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
    end else begin
      if (m_ipmeta_valid && m_ipmeta_ready) m_ipmeta_valid <= 1'b0;
      if (meta_hs) begin
        src_port       <= s_meta[63:48];
        dst_port       <= s_meta[47:32];
        payload_len    <= s_meta[31:16];
        udp_len        <= meta_udp_len;
        m_ipmeta       <= {s_meta[127:96], s_meta[95:64], meta_udp_len};
        m_ipmeta_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (adv) m_axis_tvalid <= 1'b0;
        end
        HEADER: begin
          if (adv) begin
            m_axis_tdata  <= hdr_word;
            m_axis_tkeep  <= 8'hFF;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (payload_len == 16'd0);
          end
        end
        PAYLOAD: begin
          if (adv) begin
            if (s_axis_tvalid) begin
              m_axis_tdata  <= s_axis_tdata;
              m_axis_tkeep  <= s_axis_tkeep;
              m_axis_tlast  <= s_axis_tlast;
              m_axis_tvalid <= 1'b1;
            end else begin
              m_axis_tvalid <= 1'b0;
            end
          end
        end
        default: m_axis_tvalid <= 1'b0;
      endcase
    end
  end

`ifdef UDP_LEN_CHECK_EN
  function automatic logic [3:0] popcnt(input logic [7:0] k);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) c = c + {3'b000, k[i]};
    return c;
  endfunction

  logic [15:0] byte_cnt;
  logic [15:0] byte_sum;

  assign byte_sum = byte_cnt + {12'h000, popcnt(s_axis_tkeep)};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_cnt    <= '0;
      len_err     <= 1'b0;
      len_err_cnt <= '0;
    end else begin
      len_err <= 1'b0;
      if (meta_hs)     byte_cnt <= '0;
      else if (pay_hs) byte_cnt <= byte_sum;
      // The tlast beat's own bytes are included via byte_sum before comparing.
      if (pay_hs && s_axis_tlast && (byte_sum != payload_len)) begin
        len_err <= 1'b1;
        if (len_err_cnt != 16'hFFFF) len_err_cnt <= len_err_cnt + 16'd1;
      end
    end
  end
`else
  assign len_err     = 1'b0;
  assign len_err_cnt = '0;
`endif

endmodule

// File: tb/tb_udp_header_insert.sv
// Scoreboard bench for udp_header_insert: expected beats and ip metadata are queued when driven
// and compared when the DUT emits them.
module tb_udp_header_insert;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [127:0] s_meta;
  logic         s_meta_valid;
  logic         s_meta_ready;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [79:0]  m_ipmeta;
  logic         m_ipmeta_valid;
  logic         m_ipmeta_ready;
  logic         len_err;
  logic [15:0]  len_err_cnt;

`ifdef UDP_LEN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  udp_header_insert #(.DATA_WIDTH(64), .META_WIDTH(128), .IPMETA_WIDTH(80)) dut (
    .clk(clk), .rstn(rstn),
    .s_meta(s_meta), .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_ipmeta(m_ipmeta), .m_ipmeta_valid(m_ipmeta_valid), .m_ipmeta_ready(m_ipmeta_ready),
    .len_err(len_err), .len_err_cnt(len_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;

  beat_t       sb[$];
  logic [79:0] ipq[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_errs = 0;
  int          err_pulses = 0;
  int          tready_seen = 0;
  bit          sink_en = 1'b0;
  bit          rand_rdy = 1'b0;
  bit          ip_hold = 1'b0;
  bit          prev_stall = 1'b0;
  logic [73:0] prev_word;
  beat_t       got_exp;
  logic [79:0] ip_exp;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send_pkt(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                          input logic [15:0] dp, input logic [15:0] len, input int nbytes,
                          input bit abort);
    logic [15:0] ul;
    logic [7:0]  kp;
    beat_t       e;
    int          cyc, nb, rem;
    ul = len + 16'd8;
    s_meta = {sip, dip, sp, dp, len, 16'h0000};
    s_meta_valid = 1'b1;
    cyc = 0;
    while (!s_meta_ready && cyc < 500) begin @(negedge clk); cyc++; end
    if (!s_meta_ready) begin
      chk("meta_accept_timeout", 0, 1);
      s_meta_valid = 1'b0;
      return;
    end
    e.d = {16'h0000, ul[7:0], ul[15:8], dp[7:0], dp[15:8], sp[7:0], sp[15:8]};
    e.k = 8'hFF;
    e.l = (len == 16'd0);
    sb.push_back(e);
    ipq.push_back({sip, dip, ul});
    @(negedge clk);
    s_meta_valid = 1'b0;
    if (len == 16'd0) return;
    nb = (nbytes + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      rem = nbytes - 8 * b;
      kp = (rem >= 8) ? 8'hFF : (8'hFF >> (8 - rem));
      s_axis_tdata  = {$urandom, $urandom};
      s_axis_tkeep  = kp;
      s_axis_tlast  = (b == nb - 1) && !abort;
      s_axis_tvalid = 1'b1;
      cyc = 0;
      while (!s_axis_tready && cyc < 500) begin @(negedge clk); cyc++; end
      if (!s_axis_tready) begin
        chk("payload_accept_timeout", 0, 1);
        s_axis_tvalid = 1'b0;
        return;
      end
      sb.push_back({s_axis_tdata, kp, s_axis_tlast});
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!abort && nbytes != int'(len)) exp_errs++;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && cyc < 2000) begin @(negedge clk); cyc++; end
    if (sb.size() != 0 || m_axis_tvalid) chk("drain_timeout", 0, 1);
  endtask

  // Sink: compares at negedge, changes its readies just after posedge.
  initial begin
    m_axis_tready  = 1'b1;
    m_ipmeta_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (sink_en) begin
        if (s_axis_tready) tready_seen++;
        if (len_err) err_pulses++;
        if (prev_stall)
          chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}, prev_word);
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_word  = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (m_axis_tvalid && m_axis_tready) begin
          if (sb.size() == 0) chk("unexpected_beat", 1, 0);
          else begin
            got_exp = sb.pop_front();
            chk("out_data", m_axis_tdata, got_exp.d);
            chk("out_keep", m_axis_tkeep, got_exp.k);
            chk("out_last", m_axis_tlast, got_exp.l);
          end
        end
        if (m_ipmeta_valid && m_ipmeta_ready) begin
          if (ipq.size() == 0) chk("unexpected_ipmeta", 1, 0);
          else begin
            ip_exp = ipq.pop_front();
            chk("ipmeta", m_ipmeta, ip_exp);
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk);
      #1;
      m_axis_tready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ipmeta_ready = ip_hold ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int seen;
    int len;
    s_meta = '0; s_meta_valid = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_meta_ready", s_meta_ready, 0);
    chk("rst_s_axis_tready", s_axis_tready, 0);
    chk("rst_m_axis_tvalid", m_axis_tvalid, 0);
    chk("rst_m_axis_tlast", m_axis_tlast, 0);
    chk("rst_m_axis_tdata", m_axis_tdata, 0);
    chk("rst_m_axis_tkeep", m_axis_tkeep, 0);
    chk("rst_m_ipmeta_valid", m_ipmeta_valid, 0);
    chk("rst_m_ipmeta", m_ipmeta, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_len_err_cnt", len_err_cnt, 0);
    rstn = 1'b1;
    sink_en = 1'b1;
    @(negedge clk);

    send_pkt(32'hC0A8_0001, 32'hC0A8_0002, 16'h1234, 16'h4791, 16'd16, 16, 1'b0);
    wait_drain();

    tready_seen = 0;
    send_pkt(32'h0A00_0001, 32'h0A00_0002, 16'h0400, 16'h0035, 16'd0, 0, 1'b0);
    wait_drain();
    chk("len0_no_s_axis_tready", tready_seen, 0);

    send_pkt(32'h0A00_0003, 32'h0A00_0004, 16'hABCD, 16'h0102, 16'd13, 13, 1'b0);
    wait_drain();
    chk("len13_err_cnt", len_err_cnt, CHK_EN ? exp_errs : 0);
    chk("len13_err_pulses", err_pulses, CHK_EN ? exp_errs : 0);

    rand_rdy = 1'b1;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 40);
      send_pkt($urandom, $urandom, 16'($urandom), 16'($urandom), 16'(len), len, 1'b0);
    end
    wait_drain();
    rand_rdy = 1'b0;

    send_pkt(32'h0A00_0005, 32'h0A00_0006, 16'h1111, 16'h2222, 16'd20, 16, 1'b0);
    wait_drain();
    repeat (2) @(negedge clk);
    chk("short_err_cnt", len_err_cnt, CHK_EN ? exp_errs : 0);
    chk("short_err_pulses", err_pulses, CHK_EN ? exp_errs : 0);

    ip_hold = 1'b1;
    repeat (2) @(negedge clk);
    send_pkt(32'h0B00_0001, 32'h0B00_0002, 16'h3333, 16'h4444, 16'd8, 8, 1'b0);
    wait_drain();
    s_meta = {32'h0B00_0003, 32'h0B00_0004, 16'h5555, 16'h6666, 16'd8, 16'h0000};
    s_meta_valid = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (s_meta_ready) seen++; end
    chk("meta_blocked_by_ipmeta", seen, 0);
    chk("ipmeta_held_valid", m_ipmeta_valid, 1);
    s_meta_valid = 1'b0;
    ip_hold = 1'b0;
    send_pkt(32'h0B00_0003, 32'h0B00_0004, 16'h5555, 16'h6666, 16'd8, 8, 1'b0);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("ipmeta_queue_empty", ipq.size(), 0);

    send_pkt(32'h0C00_0001, 32'h0C00_0002, 16'h7777, 16'h8888, 16'd32, 16, 1'b1);
    sink_en = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_m_axis_tvalid", m_axis_tvalid, 0);
    chk("midrst_m_axis_tlast", m_axis_tlast, 0);
    chk("midrst_m_ipmeta_valid", m_ipmeta_valid, 0);
    chk("midrst_s_axis_tready", s_axis_tready, 0);
    chk("midrst_s_meta_ready", s_meta_ready, 0);
    chk("midrst_len_err_cnt", len_err_cnt, 0);
    rstn = 1'b1;
    sb.delete();
    ipq.delete();
    @(negedge clk);
    chk("postrst_idle_meta_ready", s_meta_ready, 1);
    chk("postrst_s_axis_tready", s_axis_tready, 0);
    sink_en = 1'b1;
    send_pkt(32'h0D00_0001, 32'h0D00_0002, 16'h9999, 16'hAAAA, 16'd24, 24, 1'b0);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("final_ipmeta_queue_empty", ipq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/udp_header_insert.md
Name: udp_header_insert

Overview:
- Downstream of the metadata/payload alignment stage; consumes its aligned UDP metadata and AXI-Stream payload.
- Prepends one 8-byte UDP header beat to each payload on a 64-bit stream.
- Emits a compact IP-level metadata word (src/dst IP, UDP length) for the IP encapsulation stage.
- Optionally checks actual payload byte count against the metadata length.

Parameters:
- DATA_WIDTH, 64, stream width; only 64 is supported (one header beat = 8 bytes).
- META_WIDTH, 128, input metadata width.
- IPMETA_WIDTH, 80, output metadata width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- s_meta  in  META_WIDTH  [127:96] src_ip, [95:64] dst_ip, [63:48] src_port, [47:32] dst_port, [31:16] payload_len (bytes), [15:0] reserved
- s_meta_valid  in  1  metadata valid
- s_meta_ready  out  1  metadata accept
- s_axis_tdata  in  64  payload data
- s_axis_tkeep  in  8  payload byte enables
- s_axis_tvalid  in  1  payload valid
- s_axis_tready  out  1  payload ready
- s_axis_tlast  in  1  payload last
- m_axis_tdata  out  64  header+payload data
- m_axis_tkeep  out  8  byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output last
- m_ipmeta  out  IPMETA_WIDTH  [79:48] src_ip, [47:16] dst_ip, [15:0] udp_len
- m_ipmeta_valid  out  1  IP metadata valid
- m_ipmeta_ready  in  1  IP metadata accept
- len_err  out  1  one-cycle pulse on length mismatch (optional feature)
- len_err_cnt  out  16  saturating mismatch count (optional feature)

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE; s_meta_ready=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, m_ipmeta_valid=0, m_ipmeta=0, len_err=0, len_err_cnt=0. A reset mid-packet abandons the packet; no partial tlast is emitted.
- Output register advances when !m_axis_tvalid || m_axis_tready ("adv").
- IDLE:
  - s_meta_ready = (state==IDLE) && !m_ipmeta_valid && adv (combinational).
  - On meta handshake: latch fields; udp_len = payload_len + 8 (16-bit, wraps modulo 2^16, no saturation); m_ipmeta loaded, m_ipmeta_valid<=1; go to HEADER.
- HEADER:
  - When adv: drive the header beat with byte lane 0 first on the wire, network order.
  - tdata[7:0]=src_port[15:8], [15:8]=src_port[7:0], [23:16]=dst_port[15:8], [31:24]=dst_port[7:0], [39:32]=udp_len[15:8], [47:40]=udp_len[7:0], [63:48]=0 (checksum disabled).
  - tkeep=8'hFF, tvalid=1.
  - If payload_len==0: tlast=1, go to IDLE, and consume no payload.
  - Otherwise tlast=0, go to PAYLOAD.
  - Header appears on m_axis one cycle after the meta handshake.
- PAYLOAD:
  - s_axis_tready = (state==PAYLOAD) && adv (combinational).
  - Each input handshake copies tdata/tkeep/tlast into the output register the next cycle.
  - Input tlast returns to IDLE.
  - When adv holds and input has no valid beat, m_axis_tvalid<=0.
- m_ipmeta_valid holds until m_ipmeta_ready; it is independent of stream progress.
- The next meta is not accepted until m_ipmeta is consumed.
- Output data is stable while tvalid=1 and tready=0.
- Throughput: one beat per cycle in PAYLOAD under full backpressure-free flow; one bubble-free header beat per packet.

Optional Feature:
- Macro UDP_LEN_CHECK_EN.
- Defined:
  - Count payload bytes as the popcount of tkeep on each accepted beat (16-bit counter, cleared on meta accept).
  - At the input tlast beat, compare the count with payload_len.
  - On mismatch: len_err pulses for 1 cycle, and len_err_cnt increments, saturating at 16'hFFFF.
  - The stream is forwarded unmodified either way.
- Undefined: len_err and len_err_cnt are tied 0; no counter logic.

Test Plan:
- Meta src_port=0x1234, dst_port=0x4791, payload_len=16; two full beats -> 3 output beats: header tdata=64'h0000_1800_9147_3412, then payload, tlast on beat 3; m_ipmeta udp_len=24.
- payload_len=0, no payload -> single header beat, tlast=1, tkeep=FF, udp_len=8; s_axis_tready never asserted.
- payload_len=13, beats tkeep FF then 1F -> output tkeep FF, FF, 1F; with UDP_LEN_CHECK_EN, len_err stays 0.
- Random m_axis_tready (50%) over 20 packets -> output identical to ungated run; no data changes while stalled.
- payload_len=20 but actual 16 bytes, with UDP_LEN_CHECK_EN -> len_err pulse at tlast, len_err_cnt=1; stream still forwarded.
- m_ipmeta_ready held 0 -> second meta not accepted (s_meta_ready=0) until ipmeta consumed; rstn asserted mid-payload -> all valids 0 next cycle, state IDLE.
